// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: opcode encoding, result width and the
// buffered result entry (data plus flags captured at accept time).
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] data;
    logic                 zero;
    logic                 neg;
  } alu_entry_t;

  function automatic alu_entry_t make_entry(input logic [ALU_WIDTH-1:0] d);
    alu_entry_t e;
    e.data = d;
    e.zero = (d == '0);
    e.neg  = d[ALU_WIDTH-1];
    return e;
  endfunction

endpackage

// File: rtl/alu_res_fifo2.sv
// Two-entry in-order buffer of result entries. The head register doubles as the
// output register, so it keeps its last value once the buffer drains.
module alu_res_fifo2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  alu_entry_t entry_in,
  input  logic       pop,
  output alu_entry_t head,
  output logic [1:0] count,
  output logic       not_full
);

  alu_entry_t head_q, head_d;
  alu_entry_t tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       not_full_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = entry_in;
        else                 tail_d = entry_in;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Draining the last entry leaves head untouched so out_* hold their value.
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) head_d = entry_in;
        else begin
          head_d = tail_q;
          tail_d = entry_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      not_full_q <= (count_d != 2'd2);
    end
  end

  assign head     = head_q;
  assign count    = count_q;
  assign not_full = not_full_q;

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage: picks one bitwise-unit result by opcode, tags it with
// zero/negative flags and buffers up to two entries. ALU_RES_STATS_EN adds stat_count.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] and_y,
  input  logic [WIDTH-1:0] or_y,
  input  logic [WIDTH-1:0] xor_y,
  input  logic [WIDTH-1:0] nor_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg
`ifdef ALU_RES_STATS_EN
  ,
  output logic [15:0]      stat_count
`endif
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_result_stage: only DEPTH=2 is supported");
  end
  if (WIDTH != ALU_WIDTH) begin : g_bad_width
    $error("alu_result_stage: WIDTH must equal ALU_WIDTH");
  end

  alu_op_t          op;
  logic [WIDTH-1:0] sel_y;
  alu_entry_t       head;
  logic [1:0]       count;
  logic             accept;
  logic             deliver;

  assign op = alu_op_t'(in_op);

  always_comb begin
    sel_y = and_y;
    unique case (op)
      OP_AND: sel_y = and_y;
      OP_OR:  sel_y = or_y;
      OP_XOR: sel_y = xor_y;
      OP_NOR: sel_y = nor_y;
      default: sel_y = and_y;
    endcase
  end

  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  alu_res_fifo2 u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .entry_in (make_entry(sel_y)),
    .pop      (deliver),
    .head     (head),
    .count    (count),
    .not_full (in_ready)
  );

  assign out_data = head.data;
  assign out_zero = head.zero;
  assign out_neg  = head.neg;

`ifdef ALU_RES_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                         stat_q <= '0;
    else if (deliver && stat_q != '1)   stat_q <= stat_q + 16'd1;
  end

  assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; inputs driven and outputs
// sampled on the falling clock edge.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] and_y, or_y, xor_y, nor_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_neg;
`ifdef ALU_RES_STATS_EN
  logic [15:0] stat_count;
`endif

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .and_y     (and_y),
    .or_y      (or_y),
    .xor_y     (xor_y),
    .nor_y     (nor_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
`ifdef ALU_RES_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Unselected units carry distinct decoy values so a wrong mux select shows up.
  task automatic set_op(input logic [1:0] op, input logic [31:0] v);
    in_op = op;
    and_y = v ^ 32'h0101_0101;
    or_y  = v ^ 32'h0202_0202;
    xor_y = v ^ 32'h0404_0404;
    nor_y = v ^ 32'h0808_0808;
    case (op)
      2'b00: and_y = v;
      2'b01: or_y  = v;
      2'b10: xor_y = v;
      default: nor_y = v;
    endcase
  endtask

  task automatic check_out(input string tag, input logic [31:0] v);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, v);
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, v == 32'd0});
    check({tag, "_neg"}, {31'd0, out_neg}, {31'd0, v[31]});
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; and_y = '0; or_y = '0; xor_y = '0; nor_y = '0;

    // 1. reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_data", out_data, 32'd0);
    check("rst_zero", {31'd0, out_zero}, 32'd0);
    check("rst_neg", {31'd0, out_neg}, 32'd0);

    // 2. single AND op, one-cycle latency
    in_valid = 1'b1; out_ready = 1'b1; set_op(2'b00, 32'h0000_00F0);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("and1", 32'h0000_00F0);
    @(negedge clk);
    check("and1_drained", {31'd0, out_valid}, 32'd0);
    check("and1_hold", out_data, 32'h0000_00F0);

    // 3. fill to two under stall, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; set_op(2'b11, 32'h8000_0000);
    @(negedge clk);
    set_op(2'b10, 32'h0000_0000);
    @(negedge clk);
    set_op(2'b00, 32'h0000_1234);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    check_out("full_head", 32'h8000_0000);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("full_ignore", 32'h8000_0000);
    out_ready = 1'b1;
    @(negedge clk);
    check_out("drain2", 32'h0000_0000);
    check("drain_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // 4. count=1 with simultaneous accept and deliver for 10 ops
    out_ready = 1'b0; in_valid = 1'b1; set_op(2'b00, 32'hA000_0000);
    exp_q.push_back(32'hA000_0000);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_out("b2b", exp_q[0]);
      check("b2b_ready", {31'd0, in_ready}, 32'd1);
      v = (i == 6) ? 32'd0 : ((i % 3 == 0) ? 32'hF000_0000 + i : 32'h0000_0100 + i);
      in_valid = 1'b1; out_ready = 1'b1; set_op(2'(i % 4), v);
      @(negedge clk);
      void'(exp_q.pop_front());
      exp_q.push_back(v);
    end
    in_valid = 1'b0;
    check_out("b2b_last", exp_q[0]);
    @(negedge clk);
    check("b2b_empty", {31'd0, out_valid}, 32'd0);

    // 5. reset while full discards both entries
    out_ready = 1'b0; in_valid = 1'b1; set_op(2'b01, 32'h5555_0000);
    @(negedge clk);
    set_op(2'b10, 32'h0000_0007);
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst2_stale", {31'd0, out_valid}, 32'd0);
    end

`ifdef ALU_RES_STATS_EN
    // 6. deliver counter and saturation
    check("stat_rst", {16'd0, stat_count}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(2'b01, 32'h10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stat_5", {16'd0, stat_count}, 32'd5);
    force dut.stat_q = 16'hFFFF;
    #1;
    release dut.stat_q;
    in_valid = 1'b1; set_op(2'b00, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("stat_sat", {16'd0, stat_count}, 32'h0000_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
